univ_reg_seq: RTL
=================

Name: univ_reg_seq

Overview:
- Command sequencer for a WIDTH-bit universal shift register (hold / shift right / shift left / parallel load).
- Accepts a one-shot command: parallel-load a word, then apply N serial shifts.
- Drives the register select lines, reports busy and done, and exposes the register contents.
- Contains the register itself as a sub-module. Sits between a host FSM or test harness and the shift datapath.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- CNT_W, 3, width of shift-count field; max shifts per command = 2**CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROT.
- cnt  input  CNT_W  number of shifts after load.
- din  input  WIDTH  parallel load word.
- ser_in  input  1  serial input bit, sampled on every shift cycle.
- sel  output  2  select currently applied to register: 00 hold, 01 shr, 10 shl, 11 load.
- q  output  WIDTH  register contents.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, q=0, sel=00, busy=0, done=0, latched op/cnt/din=0. Release takes effect on the next clk edge.
- States: IDLE, LOAD, SHIFT, DONE. Encoding is binary.
- IDLE:
  - sel=00, q holds.
  - start=1 at edge k latches op, cnt and din, then goes to LOAD.
  - start while busy=1 is ignored. There is no queueing.
- LOAD (cycle after edge k):
  - sel=11; q<=din_latched at edge k+1.
  - Next state is SHIFT if op!=00 and cnt!=0, otherwise DONE.
- SHIFT:
  - Remaining count starts at cnt_latched and decrements per edge; sel is held for exactly cnt_latched cycles.
  - Go to DONE at the edge where the count reaches 1.
  - SHR: q<={ser_in, q[WIDTH-1:1]}, sel=01.
  - SHL: q<={q[WIDTH-2:0], ser_in}, sel=10.
  - ROT: see Optional Feature.
- DONE:
  - sel=00, done=1 for exactly one cycle, busy still 1. Next state IDLE.
  - q is final and stable from DONE onward until the next command's LOAD.
- Latency: start at edge k gives done high in the cycle after edge k+1+N, where N = effective shift count (0 for LOAD or cnt=0).
- Back-to-back commands: minimum period N+3 cycles (start is next sampled in IDLE).
- cnt=0 with any op: load only, done after LOAD.
- ser_in is not latched. It is sampled live on each SHIFT edge.
- Reset asserted mid-command aborts immediately. No done pulse; q=0.

Optional Feature:
- Macro: UNIV_REG_SEQ_ROT_EN.
- Defined: op=11 is rotate-right. q<={q[0], q[WIDTH-1:1]}, sel=01, ser_in ignored; the register core is fed q[0] as its serial input.
- Not defined: op=11 is treated as LOAD. Load only, shifts skipped, done after LOAD.

Decomposition:
- Package univ_reg_pkg holds:
  - SEL_HOLD/SEL_SHR/SEL_SHL/SEL_LOAD 2-bit constants.
  - OP_LOAD/OP_SHR/OP_SHL/OP_ROT 2-bit constants.
  - State encoding localparams ST_IDLE/ST_LOAD/ST_SHIFT/ST_DONE.
- Sub-module univ_reg_core(clk, rst, sel, data, ser_r, ser_l, q):
  - Pure WIDTH-bit universal register with async-high reset to 0.
  - The sequencer drives sel/data and muxes the serial inputs (ser_in, or q[0] for ROT).

Test Plan (WIDTH=4, CNT_W=3):
- Reset: rst=1 mid-run with q=1010 -> q=0000, sel=00, busy=0, done=0 immediately (asynchronously), before the next clk edge.
- LOAD: start, op=00, din=1011 -> q=1011 after edge k+1; done pulse in next cycle; busy high exactly 2 cycles.
- SHR: op=01, din=1000, cnt=3, ser_in=0 -> q sequence 1000, 0100, 0010, 0001; sel=01 for exactly 3 cycles; done once.
- SHL with ser_in: op=10, din=0001, cnt=2, ser_in=1 -> q 0001, 0011, 0111; start asserted during SHIFT is ignored (q unaffected).
- ROT: op=11, din=0011, cnt=2 -> with UNIV_REG_SEQ_ROT_EN: q 0011, 1001, 1100; without: q=0011, done after LOAD, no shift cycles.
- cnt=0 plus reset abort: op=01, cnt=0 -> load only. Then op=01, cnt=7, rst pulse after 2 shifts -> q=0000, no done, and the next start behaves normally.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared constants for the universal-register command sequencer: select codes,
// command opcodes and the sequencer state encoding.
package univ_reg_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROT  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // True when the opcode is followed by serial shift cycles.
    function automatic logic op_shifts(input logic [1:0] op, input logic rot_en);
        return (op == OP_SHR) || (op == OP_SHL) || (rot_en && (op == OP_ROT));
    endfunction

endpackage

// File: rtl/univ_reg_core.sv
// WIDTH-bit universal register: hold, shift right, shift left, parallel load.
// Each bit picks its next value from its neighbours or the serial inputs.
module univ_reg_core
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] data,
    input  logic             ser_r,
    input  logic             ser_l,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic right_src;
        logic left_src;

        // Shift right feeds the MSB from ser_r; shift left feeds the LSB from ser_l.
        if (gi == WIDTH - 1) begin : g_msb
            assign right_src = ser_r;
        end else begin : g_mid_r
            assign right_src = q[gi+1];
        end

        if (gi == 0) begin : g_lsb
            assign left_src = ser_l;
        end else begin : g_mid_l
            assign left_src = q[gi-1];
        end

        assign q_next[gi] = (sel == SEL_LOAD) ? data[gi]  :
                            (sel == SEL_SHR)  ? right_src :
                            (sel == SEL_SHL)  ? left_src  :
                                                q[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/univ_reg_seq.sv
// One-shot command sequencer: parallel load then N serial shifts on a universal register.
// Define UNIV_REG_SEQ_ROT_EN to make op=11 rotate right; otherwise op=11 acts as a load.
module univ_reg_seq
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] cnt,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [WIDTH-1:0] din_reg;
    logic             ser_r;

`ifdef UNIV_REG_SEQ_ROT_EN
    localparam logic ROT_EN = 1'b1;
    // Rotation recirculates the LSB into the MSB instead of taking ser_in.
    assign ser_r = (op_reg == OP_ROT) ? q[0] : ser_in;
`else
    localparam logic ROT_EN = 1'b0;
    assign ser_r = ser_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            cnt_reg   <= '0;
            din_reg   <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && start) begin
                op_reg  <= op;
                cnt_reg <= cnt;
                din_reg <= din;
            end
            if (state_reg == S_LOAD) begin
                rem_reg <= cnt_reg;
            end else if (state_reg == S_SHIFT) begin
                rem_reg <= rem_reg - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        sel        = SEL_HOLD;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                sel        = SEL_LOAD;
                state_next = (op_shifts(op_reg, ROT_EN) && cnt_reg != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                sel = (op_reg == OP_SHL) ? SEL_SHL : SEL_SHR;
                if (rem_reg == CNT_W'(1)) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);

    univ_reg_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .data (din_reg),
        .ser_r(ser_r),
        .ser_l(ser_in),
        .q    (q)
    );

endmodule
